// File: rtl/sm_bus_pkg.sv
// Shared definitions for the schoolMIPS data-side bus matrix: FSM encoding,
// default address map and error-counter sizing.
package sm_bus_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      RESP   = ST_RESP
   } bus_state_t;

   localparam logic [31:0] SM_BUS_RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] SM_BUS_RAM_MASK  = 32'h0000_C000;
   localparam logic [31:0] SM_BUS_GPIO_BASE = 32'h0000_7F00;
   localparam logic [31:0] SM_BUS_GPIO_MASK = 32'h0000_FFF0;
   localparam logic [31:0] SM_BUS_PWM_BASE  = 32'h0000_7F10;
   localparam logic [31:0] SM_BUS_PWM_MASK  = 32'h0000_FFF0;
   localparam logic [31:0] SM_BUS_ALS_BASE  = 32'h0000_7F20;
   localparam logic [31:0] SM_BUS_ALS_MASK  = 32'h0000_FFF0;
   // Slots 4 and 5 are decoded but have no peripheral attached yet.
   localparam logic [31:0] SM_BUS_RSV4_BASE = 32'h0000_7F30;
   localparam logic [31:0] SM_BUS_RSV5_BASE = 32'h0000_7F40;
   localparam logic [31:0] SM_BUS_RSV_MASK  = 32'h0000_FFF0;

   localparam int SM_BUS_NSLAVE_DEF = 6;

   localparam logic [6*32-1:0] SM_BUS_DEC_BASE_DEF = {
      SM_BUS_RSV5_BASE, SM_BUS_RSV4_BASE, SM_BUS_ALS_BASE,
      SM_BUS_PWM_BASE, SM_BUS_GPIO_BASE, SM_BUS_RAM_BASE};
   localparam logic [6*32-1:0] SM_BUS_DEC_MASK_DEF = {
      SM_BUS_RSV_MASK, SM_BUS_RSV_MASK, SM_BUS_ALS_MASK,
      SM_BUS_PWM_MASK, SM_BUS_GPIO_MASK, SM_BUS_RAM_MASK};

   localparam int SM_BUS_ERR_CNT_W = 8;

   function automatic int sm_bus_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sm_bus_decoder.sv
// Combinational address decoder: masked compare against each slave base,
// lowest matching slot wins, miss when nothing matches.
module sm_bus_decoder
   import sm_bus_pkg::*;
#(
   parameter int                   NSLAVE   = SM_BUS_NSLAVE_DEF,
   parameter int                   AW       = 32,
   parameter logic [NSLAVE*AW-1:0] DEC_BASE = SM_BUS_DEC_BASE_DEF,
   parameter logic [NSLAVE*AW-1:0] DEC_MASK = SM_BUS_DEC_MASK_DEF,
   parameter int                   IW       = sm_bus_idx_w(NSLAVE)
) (
   input  logic [AW-1:0] addr,
   output logic [IW-1:0] index,
   output logic          miss
);

   // Scan from the top so the last assignment is the lowest matching index.
   always_comb begin
      index = '0;
      miss  = 1'b1;
      for (int i = NSLAVE - 1; i >= 0; i--) begin
         if ((addr & DEC_MASK[i*AW +: AW]) == DEC_BASE[i*AW +: AW]) begin
            index = IW'(i);
            miss  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sm_bus_matrix.sv
// Data-side bus interconnect: latches one master request, strobes the decoded
// slave until it answers or times out, then returns data or a bus error.
module sm_bus_matrix
   import sm_bus_pkg::*;
#(
   parameter int                   NSLAVE   = SM_BUS_NSLAVE_DEF,
   parameter int                   AW       = 32,
   parameter int                   DW       = 32,
   parameter int                   TIMEOUT  = 15,
   parameter logic [NSLAVE*AW-1:0] DEC_BASE = SM_BUS_DEC_BASE_DEF,
   parameter logic [NSLAVE*AW-1:0] DEC_MASK = SM_BUS_DEC_MASK_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        bReq,
   input  logic [AW-1:0]               bAddr,
   input  logic                        bWrite,
   input  logic [DW-1:0]               bWData,
   output logic [DW-1:0]               bRData,
   output logic                        bReady,
   output logic                        bErr,
   output logic                        bBusy,
   output logic [NSLAVE-1:0]           sSel,
   output logic [AW-1:0]               sAddr,
   output logic                        sWrite,
   output logic [DW-1:0]               sWData,
   input  logic [NSLAVE*DW-1:0]        sRData,
   input  logic [NSLAVE-1:0]           sReady,
   output logic [SM_BUS_ERR_CNT_W-1:0] errCount,
   output logic [AW-1:0]               errAddr,
   output logic [1:0]                  fsm_state
);

   localparam int         IW      = sm_bus_idx_w(NSLAVE);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   // Handshake: a request is taken only in IDLE (bBusy=0) when bReq=1; the
   // slave completes by raising its sReady bit while its sSel bit is high;
   // the master sees exactly one bReady cycle per accepted request.

   bus_state_t    state, state_nxt;
   logic [IW-1:0] idx_q;
   logic          err_q;
   logic [7:0]    tcnt;

   logic [IW-1:0] dec_index;
   logic          dec_miss;
   logic          sel_ready;
   logic [DW-1:0] sel_rdata;
   logic          take_ready;
   logic          take_timeout;

   sm_bus_decoder #(
      .NSLAVE   (NSLAVE),
      .AW       (AW),
      .DEC_BASE (DEC_BASE),
      .DEC_MASK (DEC_MASK),
      .IW       (IW)
   ) u_decoder (
      .addr  (bAddr),
      .index (dec_index),
      .miss  (dec_miss)
   );

   // Only the latched slave's ready and data are looked at.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NSLAVE; i++) begin
         if (idx_q == IW'(i)) begin
            sel_ready = sReady[i];
            sel_rdata = sRData[i*DW +: DW];
         end
      end
   end

   always_comb begin
      sSel = '0;
      if (state == ACCESS) begin
         for (int i = 0; i < NSLAVE; i++) begin
            sSel[i] = (idx_q == IW'(i));
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      take_ready   = 1'b0;
      take_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (bReq) state_nxt = dec_miss ? RESP : ACCESS;
         end
         ACCESS: begin
            // Ready is tested first so a same-cycle ready beats the timeout.
            if (sel_ready) begin
               state_nxt  = RESP;
               take_ready = 1'b1;
            end else if (tcnt == TO_LAST) begin
               state_nxt    = RESP;
               take_timeout = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx_q    <= '0;
         err_q    <= 1'b0;
         tcnt     <= '0;
         bRData   <= '0;
         sAddr    <= '0;
         sWrite   <= 1'b0;
         sWData   <= '0;
         errCount <= '0;
         errAddr  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               tcnt <= '0;
               if (bReq) begin
                  sAddr  <= bAddr;
                  sWrite <= bWrite;
                  sWData <= bWData;
                  idx_q  <= dec_index;
                  err_q  <= dec_miss;
                  if (dec_miss) bRData <= '0;
               end
            end
            ACCESS: begin
               tcnt <= tcnt + 8'd1;
               if (take_ready) begin
                  bRData <= sWrite ? '0 : sel_rdata;
                  err_q  <= 1'b0;
               end else if (take_timeout) begin
                  bRData <= '0;
                  err_q  <= 1'b1;
               end
            end
            RESP: begin
               if (err_q) begin
                  if (errCount != '1) errCount <= errCount + 1'b1;
                  errAddr <= sAddr;
               end
            end
            default: ;
         endcase
      end
   end

   assign bReady    = (state == RESP);
   assign bErr      = (state == RESP) && err_q;
   assign bBusy     = (state != IDLE);
   assign fsm_state = state;

endmodule

// File: tb/tb_sm_bus_matrix.sv
// Directed bench for sm_bus_matrix: requests push expected completions into a
// queue that a negedge monitor pops and compares whenever bReady is seen.
`timescale 1ns/1ps
module tb_sm_bus_matrix;
   import sm_bus_pkg::*;

   localparam int NS    = 6;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int EXP_W = 79;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic           bReq   = 1'b0;
   logic [AW-1:0]  bAddr  = '0;
   logic           bWrite = 1'b0;
   logic [DW-1:0]  bWData = '0;
   logic [NS*DW-1:0] sRData;
   logic [NS-1:0]  sReady;

   logic [DW-1:0] bRData, sWData, bRData_b, sWData_b;
   logic          bReady, bErr, bBusy, sWrite, bReady_b, bErr_b, bBusy_b, sWrite_b;
   logic [NS-1:0] sSel, sSel_b;
   logic [AW-1:0] sAddr, errAddr, sAddr_b, errAddr_b;
   logic [7:0]    errCount, errCount_b;
   logic [1:0]    fsm_state, fsm_state_b;

   sm_bus_matrix dut (
      .clk(clk), .rst(rst), .bReq(bReq), .bAddr(bAddr), .bWrite(bWrite),
      .bWData(bWData), .bRData(bRData), .bReady(bReady), .bErr(bErr),
      .bBusy(bBusy), .sSel(sSel), .sAddr(sAddr), .sWrite(sWrite),
      .sWData(sWData), .sRData(sRData), .sReady(sReady),
      .errCount(errCount), .errAddr(errAddr), .fsm_state(fsm_state)
   );

   // Same traffic, but slot 3 overlaps slot 1 at 0x7F00: slot 1 must win.
   sm_bus_matrix #(
      .DEC_BASE({32'h7F40, 32'h7F30, 32'h7F00, 32'h7F10, 32'h7F00, 32'h0000})
   ) dut_ovl (
      .clk(clk), .rst(rst), .bReq(bReq), .bAddr(bAddr), .bWrite(bWrite),
      .bWData(bWData), .bRData(bRData_b), .bReady(bReady_b), .bErr(bErr_b),
      .bBusy(bBusy_b), .sSel(sSel_b), .sAddr(sAddr_b), .sWrite(sWrite_b),
      .sWData(sWData_b), .sRData(sRData), .sReady(sReady),
      .errCount(errCount_b), .errAddr(errAddr_b), .fsm_state(fsm_state_b)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: selected slave answers after wait_cfg extra cycles; noise
   // drives ready on other slots.
   int            acc      = 0;
   int            wait_cfg = 0;
   logic [NS-1:0] noise    = '0;
   always @(posedge clk) acc <= (sSel != '0) ? acc + 1 : 0;
   assign sReady = ((acc == wait_cfg) ? sSel : '0) | noise;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int exp_errs = 0;
   logic [AW-1:0] exp_err_addr = '0;

   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] e;
   logic [AW-1:0] cur_addr  = '0;
   logic [DW-1:0] cur_wdata = '0;
   logic          cur_write = 1'b0;
   logic [NS-1:0] sel_acc   = '0;
   logic [NS-1:0] sel_acc_b = '0;
   int            sel_cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         sel_acc   = '0;
         sel_acc_b = '0;
         sel_cyc   = 0;
      end else begin
         if (sSel != '0) begin
            sel_acc |= sSel;
            sel_cyc++;
            chk("s_addr_hold", sAddr, cur_addr);
            chk("s_wdata_hold", sWData, cur_wdata);
            chk("s_write_hold", 32'(sWrite), 32'(cur_write));
         end
         sel_acc_b |= sSel_b;
         if (bReady) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready actual=1 required=0 cycle=%0d", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("done_cycle", 32'(cyc), e[78:47]);
               chk("rdata", bRData, e[46:15]);
               chk("err", 32'(bErr), 32'(e[14]));
               chk("sel", 32'(sel_acc), 32'(e[13:8]));
               chk("sel_cycles", 32'(sel_cyc), 32'(e[7:0]));
               chk("ovl_ready", 32'(bReady_b), 32'd1);
               chk("ovl_sel", 32'(sel_acc_b), 32'(e[13:8]));
               chk("ovl_rdata", bRData_b, e[46:15]);
               chk("ovl_err", 32'(bErr_b), 32'(e[14]));
            end
            sel_acc   = '0;
            sel_acc_b = '0;
            sel_cyc   = 0;
            done_cnt++;
         end
      end
   end

   task automatic push_exp(input int done_c, input logic [31:0] rd, input logic er,
                           input logic [NS-1:0] sl, input int sc);
      exp_q.push_back({32'(done_c), rd, er, sl, 8'(sc)});
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL completion_timeout actual=%0d required=%0d", done_cnt, target);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input int wt, input logic [31:0] rd, input logic er,
                         input logic [NS-1:0] sl, input int sc, input int lat);
      int d0;
      d0 = done_cnt;
      wait_cfg  = wt;
      cur_addr  = a;
      cur_write = w;
      cur_wdata = wd;
      push_exp(cyc + lat, rd, er, sl, sc);
      bReq = 1'b1; bAddr = a; bWrite = w; bWData = wd;
      @(posedge clk); #1;
      bReq = 1'b0;
      wait_done(d0 + 1);
   endtask

   task automatic note_err(input logic [31:0] a);
      if (exp_errs < 255) exp_errs++;
      exp_err_addr = a;
   endtask

   task automatic chk_err();
      chk("err_count", 32'(errCount), 32'(exp_errs));
      chk("err_addr", errAddr, exp_err_addr);
      chk("ovl_err_count", 32'(errCount_b), 32'(exp_errs));
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      sRData = {32'h6060_0005, 32'h4040_0004, 32'h3030_0003,
                32'hBEEF_0002, 32'hCAFE_0001, 32'h1234_5678};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", bRData, 32'h0);
      chk("rst_ready", 32'(bReady), 32'h0);
      chk("rst_err", 32'(bErr), 32'h0);
      chk("rst_busy", 32'(bBusy), 32'h0);
      chk("rst_sel", 32'(sSel), 32'h0);
      chk("rst_saddr", sAddr, 32'h0);
      chk("rst_swrite", 32'(sWrite), 32'h0);
      chk("rst_swdata", sWData, 32'h0);
      chk("rst_errcount", 32'(errCount), 32'h0);
      chk("rst_erraddr", errAddr, 32'h0);
      chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      @(posedge clk); #1;
      rst = 1'b0;

      // RAM read, zero wait: sSel in cycle 1, bReady in cycle 2
      do_req(32'h0000_0010, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0, 6'b000001, 1, 2);
      // GPIO write, 3 wait cycles: 4 strobe cycles, data zeroed on write
      do_req(32'h0000_7F04, 1'b1, 32'h0000_00A5, 3, 32'h0, 1'b0, 6'b000010, 4, 5);
      chk("busy_after_write", 32'(bBusy), 32'h0);
      // Unmapped read
      do_req(32'h0000_7F80, 1'b0, 32'h0, 0, 32'h0, 1'b1, 6'b000000, 0, 1);
      note_err(32'h0000_7F80);
      chk_err();
      // Unmapped write: nothing strobed
      do_req(32'h0000_9000, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 6'b000000, 0, 1);
      note_err(32'h0000_9000);
      chk_err();
      // Ready on the 15th ACCESS cycle beats the timeout
      do_req(32'h0000_7F14, 1'b0, 32'h0, 14, 32'hBEEF_0002, 1'b0, 6'b000100, 15, 16);
      chk_err();
      // Timeout with ready noise on every unselected slot
      noise = 6'b111011;
      do_req(32'h0000_7F10, 1'b0, 32'h0, 1000, 32'h0, 1'b1, 6'b000100, 15, 16);
      noise = '0;
      note_err(32'h0000_7F10);
      chk_err();
      // Reserved slot 4, one wait cycle
      do_req(32'h0000_7F34, 1'b0, 32'h0, 1, 32'h4040_0004, 1'b0, 6'b010000, 2, 3);

      // Back-to-back: bReq held 6 cycles gives two accepts, 3 cycles apart
      d0 = done_cnt;
      wait_cfg = 0; cur_addr = 32'h30; cur_write = 1'b0; cur_wdata = 32'h0;
      push_exp(cyc + 2, 32'h1234_5678, 1'b0, 6'b000001, 1);
      push_exp(cyc + 5, 32'h1234_5678, 1'b0, 6'b000001, 1);
      bReq = 1'b1; bAddr = 32'h30; bWrite = 1'b0; bWData = 32'h0;
      repeat (6) begin @(posedge clk); #1; end
      bReq = 1'b0;
      wait_done(d0 + 2);
      chk("b2b_count", 32'(done_cnt - d0), 32'd2);

      // bReq while busy is ignored
      d0 = done_cnt;
      wait_cfg = 2; cur_addr = 32'h40; cur_write = 1'b0; cur_wdata = 32'h0;
      push_exp(cyc + 4, 32'h1234_5678, 1'b0, 6'b000001, 3);
      bReq = 1'b1; bAddr = 32'h40; bWrite = 1'b0; bWData = 32'h0;
      @(posedge clk); #1;
      bReq = 1'b0;
      @(posedge clk); #1;
      bReq = 1'b1; bAddr = 32'h7F80; bWrite = 1'b1; bWData = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bReq = 1'b0;
      wait_done(d0 + 1);
      repeat (5) begin @(posedge clk); #1; end
      chk("busy_single", 32'(done_cnt - d0), 32'd1);
      chk_err();

      // Reset during ACCESS
      wait_cfg = 1000; cur_addr = 32'h7F18; cur_write = 1'b0; cur_wdata = 32'h0;
      bReq = 1'b1; bAddr = 32'h7F18; bWrite = 1'b0; bWData = 32'h0;
      @(posedge clk); #1;
      bReq = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst_busy", 32'(bBusy), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_sel", 32'(sSel), 32'h0);
      chk("post_rst_busy", 32'(bBusy), 32'h0);
      chk("post_rst_ready", 32'(bReady), 32'h0);
      chk("post_rst_state", 32'(fsm_state), 32'(ST_IDLE));
      exp_errs = 0;
      exp_err_addr = '0;
      chk_err();
      repeat (20) begin @(posedge clk); #1; end

      // Repeated timeouts saturate the error counter
      for (int i = 0; i < 300; i++) begin
         do_req(32'h0000_7F1C, 1'b0, 32'h0, 1000, 32'h0, 1'b1, 6'b000100, 15, 16);
         note_err(32'h0000_7F1C);
         chk_err();
      end
      chk("err_sat", 32'(errCount), 32'd255);

      do_req(32'h0000_0014, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0, 6'b000001, 1, 2);

      repeat (5) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
